axi_rd_arbiter: RTL and testbench

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/axi_rd_arbiter.sv | 170 +++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI read arbiter. One read is outstanding at a time: a
// requester wins the shared slave, its AR beat is forwarded, then every R
// beat is routed back to it until the slave signals rlast. Ownership
// alternates round-robin when both requesters want the slave.
module axi_rd_arbiter #(
    parameter int addr_wid_axi = 32,
    parameter int data_wid     = 32,
    parameter int asize        = $clog2(data_wid / 8)
) (
    input  logic                    aclk,
    input  logic                    areset,
    // requester 0
    input  logic [1:0]              m0_arid,
    input  logic [addr_wid_axi-1:0] m0_araddr,
    input  logic [7:0]              m0_arlen,
    input  logic [asize-1:0]        m0_arsize,
    input  logic [1:0]              m0_arburst,
    input  logic                    m0_arvalid,
    output logic                    m0_arready,
    output logic [data_wid-1:0]     m0_rdata,
    output logic [1:0]              m0_rresp,
    output logic                    m0_rlast,
    output logic                    m0_rvalid,
    input  logic                    m0_rready,
    // requester 1
    input  logic [1:0]              m1_arid,
    input  logic [addr_wid_axi-1:0] m1_araddr,
    input  logic [7:0]              m1_arlen,
    input  logic [asize-1:0]        m1_arsize,
    input  logic [1:0]              m1_arburst,
    input  logic                    m1_arvalid,
    output logic                    m1_arready,
    output logic [data_wid-1:0]     m1_rdata,
    output logic [1:0]              m1_rresp,
    output logic                    m1_rlast,
    output logic                    m1_rvalid,
    input  logic                    m1_rready,
    // shared slave
    output logic [1:0]              s_arid,
    output logic [addr_wid_axi-1:0] s_araddr,
    output logic [7:0]              s_arlen,
    output logic [asize-1:0]        s_arsize,
    output logic [1:0]              s_arburst,
    output logic                    s_arvalid,
    input  logic                    s_arready,
    input  logic [data_wid-1:0]     s_rdata,
    input  logic [1:0]              s_rresp,
    input  logic                    s_rlast,
    input  logic                    s_rvalid,
    output logic                    s_rready,
    // status
    output logic                    grant,
    output logic                    busy,
    output logic                    len_err,
    output logic [1:0]              dbg_state
);

    // Handshake rule on every channel: a beat transfers on the rising edge
    // where valid and ready are both high; valid, once raised, is expected
    // to hold with stable payload until that edge.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t     r_state;
    logic       r_grant;
    logic       r_last_grant;
    logic       r_busy;
    logic       r_len_err;
    logic [7:0] r_len_q;
    logic [7:0] r_beat_cnt;

    logic w_in_addr;
    logic w_in_data;
    logic w_any_req;
    logic w_winner;
    logic w_ar_hs;
    logic w_r_hs;

    assign w_in_addr = (r_state == ST_ADDR);
    assign w_in_data = (r_state == ST_DATA);
    assign w_any_req = m0_arvalid | m1_arvalid;
    // Contention goes to the requester that did not own the last burst.
    assign w_winner  = (m0_arvalid & m1_arvalid) ? ~r_last_grant : m1_arvalid;
    assign w_ar_hs   = s_arvalid & s_arready;
    assign w_r_hs    = w_in_data & s_rvalid & s_rready;

    assign grant     = r_grant;
    assign busy      = r_busy;
    assign len_err   = r_len_err;
    assign dbg_state = r_state;

    // Ownership FSM with burst-length bookkeeping and registered status.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state      <= ST_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_busy       <= 1'b0;
            r_len_err    <= 1'b0;
            r_len_q      <= 8'd0;
            r_beat_cnt   <= 8'd0;
        end else begin
            r_len_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant <= w_winner;
                        r_busy  <= 1'b1;
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (w_ar_hs) begin
                        r_len_q    <= s_arlen;
                        r_beat_cnt <= 8'd0;
                        r_state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_r_hs) begin
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                        // Flag a slave whose rlast disagrees with arlen; the
                        // burst is still closed only by rlast.
                        r_len_err  <= s_rlast ? (r_beat_cnt != r_len_q)
                                              : (r_beat_cnt == r_len_q);
                        if (s_rlast) begin
                            r_last_grant <= r_grant;
                            r_busy       <= 1'b0;
                            r_state      <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Route AR payload from the owner; valid/ready only pass in ADDR.
    always_comb begin
        s_arid     = r_grant ? m1_arid    : m0_arid;
        s_araddr   = r_grant ? m1_araddr  : m0_araddr;
        s_arlen    = r_grant ? m1_arlen   : m0_arlen;
        s_arsize   = r_grant ? m1_arsize  : m0_arsize;
        s_arburst  = r_grant ? m1_arburst : m0_arburst;
        s_arvalid  = w_in_addr & (r_grant ? m1_arvalid : m0_arvalid);
        m0_arready = w_in_addr & ~r_grant & s_arready;
        m1_arready = w_in_addr &  r_grant & s_arready;
    end

    // Route R beats to the owner; valid/ready only pass in DATA.
    always_comb begin
        m0_rdata  = s_rdata;
        m0_rresp  = s_rresp;
        m0_rlast  = s_rlast;
        m1_rdata  = s_rdata;
        m1_rresp  = s_rresp;
        m1_rlast  = s_rlast;
        m0_rvalid = w_in_data & ~r_grant & s_rvalid;
        m1_rvalid = w_in_data &  r_grant & s_rvalid;
        s_rready  = w_in_data & (r_grant ? m1_rready : m0_rready);
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for the two-requester AXI read arbiter.
module tb_axi_rd_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 2;

    logic          aclk;
    logic          areset;
    logic [1:0]    m0_arid, m1_arid, s_arid;
    logic [AW-1:0] m0_araddr, m1_araddr, s_araddr;
    logic [7:0]    m0_arlen, m1_arlen, s_arlen;
    logic [SW-1:0] m0_arsize, m1_arsize, s_arsize;
    logic [1:0]    m0_arburst, m1_arburst, s_arburst;
    logic          m0_arvalid, m1_arvalid, s_arvalid;
    logic          m0_arready, m1_arready, s_arready;
    logic [DW-1:0] m0_rdata, m1_rdata, s_rdata;
    logic [1:0]    m0_rresp, m1_rresp, s_rresp;
    logic          m0_rlast, m1_rlast, s_rlast;
    logic          m0_rvalid, m1_rvalid, s_rvalid;
    logic          m0_rready, m1_rready, s_rready;
    logic          grant, busy, len_err;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    axi_rd_arbiter #(.addr_wid_axi(AW), .data_wid(DW)) dut (
        .aclk(aclk), .areset(areset),
        .m0_arid(m0_arid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen),
        .m0_arsize(m0_arsize), .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid),
        .m0_arready(m0_arready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
        .m0_rlast(m0_rlast), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_arid(m1_arid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen),
        .m1_arsize(m1_arsize), .m1_arburst(m1_arburst), .m1_arvalid(m1_arvalid),
        .m1_arready(m1_arready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
        .m1_rlast(m1_rlast), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arvalid(s_arvalid),
        .s_arready(s_arready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .grant(grant), .busy(busy), .len_err(len_err), .dbg_state(dbg_state)
    );

    // clock / reset
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_arid = 2'd0; m0_araddr = '0; m0_arlen = 8'd0; m0_arsize = '0; m0_arburst = 2'd0;
        m1_arid = 2'd0; m1_araddr = '0; m1_arlen = 8'd0; m1_arsize = '0; m1_arburst = 2'd0;
        m0_arvalid = 1'b0; m1_arvalid = 1'b0; m0_rready = 1'b0; m1_rready = 1'b0;
        s_arready = 1'b0; s_rdata = '0; s_rresp = 2'd0; s_rlast = 1'b0; s_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
    endtask

    // quiet-outputs check used after reset and outside bursts
    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"},      32'(busy),       32'd0);
        chk({tag, "_s_arvalid"}, 32'(s_arvalid),  32'd0);
        chk({tag, "_s_rready"},  32'(s_rready),   32'd0);
        chk({tag, "_m0_arready"},32'(m0_arready), 32'd0);
        chk({tag, "_m1_arready"},32'(m1_arready), 32'd0);
        chk({tag, "_m0_rvalid"}, 32'(m0_rvalid),  32'd0);
        chk({tag, "_m1_rvalid"}, 32'(m1_rvalid),  32'd0);
        chk({tag, "_len_err"},   32'(len_err),    32'd0);
    endtask

    initial begin
        int k;
        clear_inputs();
        areset = 1'b1;

        // ---- reset state ----
        #3;
        chk_quiet("rst");
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        tick();
        areset = 1'b0;

        // ---- single read, m0 arlen=3 ----
        m0_arvalid = 1'b1; m0_araddr = 32'h0000_1000; m0_arlen = 8'd3;
        m0_arid = 2'd1; m0_arsize = 2'd2; m0_arburst = 2'd1;
        s_arready = 1'b1;
        #1;
        chk("t1_idle_arvalid", 32'(s_arvalid), 32'd0);
        tick();
        chk("t1_busy",    32'(busy),      32'd1);
        chk("t1_grant",   32'(grant),     32'd0);
        chk("t1_state",   32'(dbg_state), 32'd1);
        chk("t1_arvalid", 32'(s_arvalid), 32'd1);
        chk("t1_araddr",  s_araddr,       32'h0000_1000);
        chk("t1_arlen",   32'(s_arlen),   32'd3);
        chk("t1_arid",    32'(s_arid),    32'd1);
        chk("t1_arsize",  32'(s_arsize),  32'd2);
        chk("t1_arburst", 32'(s_arburst), 32'd1);
        chk("t1_m0_arready", 32'(m0_arready), 32'd1);
        chk("t1_m1_arready", 32'(m1_arready), 32'd0);
        tick();
        m0_arvalid = 1'b0; s_arready = 1'b0;
        chk("t1_data_state", 32'(dbg_state), 32'd2);
        m0_rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_rvalid = 1'b1;
            s_rdata  = 32'hA000_0000 + 32'(i);
            s_rresp  = 2'(i);
            s_rlast  = (i == 3);
            #1;
            chk("t1_m0_rvalid", 32'(m0_rvalid), 32'd1);
            chk("t1_m0_rdata",  m0_rdata,       32'hA000_0000 + 32'(i));
            chk("t1_m0_rresp",  32'(m0_rresp),  32'(i % 4));
            chk("t1_m0_rlast",  32'(m0_rlast),  32'(i == 3));
            chk("t1_m1_rvalid", 32'(m1_rvalid), 32'd0);
            chk("t1_s_rready",  32'(s_rready),  32'd1);
            tick();
        end
        s_rvalid = 1'b0; s_rlast = 1'b0; m0_rready = 1'b0;
        #1;
        chk_quiet("t1_end");

        // ---- contention from reset, arlen=0 bursts ----
        do_reset();
        m0_arvalid = 1'b1; m0_araddr = 32'h0000_0100;
        m1_arvalid = 1'b1; m1_araddr = 32'h0000_0200;
        s_arready = 1'b1; s_rvalid = 1'b1; s_rlast = 1'b1;
        m0_rready = 1'b1; m1_rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_grant",  32'(grant), 32'(i % 2));
            chk("t2_araddr", s_araddr, (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
            tick();
            chk("t2_m0_rvalid", 32'(m0_rvalid), 32'(i % 2 == 0));
            chk("t2_m1_rvalid", 32'(m1_rvalid), 32'(i % 2 == 1));
            tick();
            chk("t2_idle_busy", 32'(busy), 32'd0);
            chk("t2_len_err",   32'(len_err), 32'd0);
        end
        clear_inputs();

        // ---- backpressure, m1 arlen=7 ----
        m1_arvalid = 1'b1; m1_araddr = 32'h0000_3000; m1_arlen = 8'd7;
        s_arready = 1'b1;
        tick();
        chk("t3_grant", 32'(grant), 32'd1);
        tick();
        m1_arvalid = 1'b0; s_arready = 1'b0;
        k = 0;
        for (int c = 0; c < 32 && k < 8; c++) begin
            m1_rready = (c % 2 == 0);
            s_rvalid  = 1'b1;
            s_rdata   = 32'hB000_0000 + 32'(k);
            s_rlast   = (k == 7);
            #1;
            chk("t3_s_rready",  32'(s_rready),  32'(m1_rready));
            chk("t3_m1_rvalid", 32'(m1_rvalid), 32'd1);
            chk("t3_m1_rdata",  m1_rdata,       32'hB000_0000 + 32'(k));
            chk("t3_m0_rvalid", 32'(m0_rvalid), 32'd0);
            tick();
            if (m1_rready) k++;
        end
        chk("t3_beats", 32'(k), 32'd8);
        clear_inputs();
        #1;
        chk_quiet("t3_end");

        // ---- length error: arlen=2, rlast on beat 2 ----
        m0_arvalid = 1'b1; m0_araddr = 32'h0000_4000; m0_arlen = 8'd2;
        s_arready = 1'b1;
        tick();
        chk("t4_grant", 32'(grant), 32'd0);
        tick();
        m0_arvalid = 1'b0; m0_rready = 1'b1;
        s_rvalid = 1'b1; s_rlast = 1'b0;
        tick();
        chk("t4_no_err_beat1", 32'(len_err), 32'd0);
        s_rlast = 1'b1;
        tick();
        s_rvalid = 1'b0; s_rlast = 1'b0;
        chk("t4_len_err_pulse", 32'(len_err),   32'd1);
        chk("t4_state_idle",    32'(dbg_state), 32'd0);
        chk("t4_busy",          32'(busy),      32'd0);
        tick();
        chk("t4_len_err_clear", 32'(len_err), 32'd0);
        clear_inputs();

        // ---- reset mid-DATA (m1 arlen=3, reset on beat 2) ----
        m1_arvalid = 1'b1; m1_arlen = 8'd3; s_arready = 1'b1;
        tick();
        chk("t5_grant", 32'(grant), 32'd1);
        tick();
        m1_arvalid = 1'b0; m1_rready = 1'b1; s_rvalid = 1'b1;
        tick();
        chk("t5_beat2_rvalid", 32'(m1_rvalid), 32'd1);
        areset = 1'b1;
        #1;
        chk_quiet("t5_rst");
        chk("t5_rst_grant", 32'(grant), 32'd0);
        do_reset();
        m0_arvalid = 1'b1; m1_arvalid = 1'b1; s_arready = 1'b1;
        tick();
        chk("t5_after_grant", 32'(grant), 32'd0);
        m1_arvalid = 1'b0;
        tick();
        m0_arvalid = 1'b0; m0_rready = 1'b1; s_rvalid = 1'b1; s_rlast = 1'b1;
        tick();
        clear_inputs();

        // ---- slave AR stall for 5 cycles ----
        m1_arvalid = 1'b1; m1_araddr = 32'h0000_5A5C; m1_arlen = 8'd0; m1_arid = 2'd2;
        tick();
        chk("t6_grant", 32'(grant), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("t6_arvalid",    32'(s_arvalid),  32'd1);
            chk("t6_araddr",     s_araddr,        32'h0000_5A5C);
            chk("t6_arid",       32'(s_arid),     32'd2);
            chk("t6_m1_arready", 32'(m1_arready), 32'd0);
            chk("t6_state",      32'(dbg_state),  32'd1);
            tick();
        end
        s_arready = 1'b1;
        #1;
        chk("t6_m1_arready_acc", 32'(m1_arready), 32'd1);
        chk("t6_m0_arready_acc", 32'(m0_arready), 32'd0);
        tick();
        chk("t6_data_state", 32'(dbg_state), 32'd2);
        m1_arvalid = 1'b0; s_arready = 1'b0;
        m1_rready = 1'b1; s_rvalid = 1'b1; s_rlast = 1'b1;
        tick();
        clear_inputs();
        #1;
        chk_quiet("t6_end");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
